// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions: data width, bubble encoding, fetch FSM states
// and the IF/ID pipeline record.
package fetch_stage_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR_VAL = 32'h0000_0013;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            valid;
    } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: holds on stall, loads a bubble on flush
// (flush wins over stall), otherwise captures the fetched record.
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_VAL
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   stall,
    input  logic   flush,
    input  if_id_t d,
    output if_id_t q
);

    // NOTE: non-blocking assignments in clocked logic so every register samples
    // pre-edge values; the reset arm gives a defined bubble rather than X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '{pc: RESET_PC, instr: NOP_INSTR, valid: 1'b0};
        end else if (flush) begin
            // NOTE: flush is tested before stall so a squash is never lost to a hold.
            q <= '{pc: d.pc, instr: NOP_INSTR, valid: 1'b0};
        end else if (!stall) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, BOOT/RUN sequencing and next-PC select
// feeding a synchronous-read instruction memory and the IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_VAL
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_stall_fetch,
    input  logic        i_stall_decode,
    input  logic        i_flush_decode,
    input  logic        i_pc_sel,
    input  logic [31:0] i_alu_data,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_pc_decode,
    output logic [31:0] o_instr_decode,
    output logic        o_insn_vld_decode
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            stall;
    logic            if_stall, if_flush;
    if_id_t          if_id_d, if_id_q;
    logic            unused_alu_lsbs;

    assign stall = i_stall_fetch | i_stall_decode;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_d  = state_q;
        pc_d     = pc_q;
        if_stall = 1'b0;
        if_flush = 1'b0;
        case (state_q)
            BOOT: begin
                // Hazard inputs are ignored; present RESET_PC and feed a bubble.
                state_d  = RUN;
                pc_d     = RESET_PC;
                if_flush = 1'b1;
            end
            RUN: begin
                if (i_pc_sel) begin
                    pc_d = {i_alu_data[XLEN-1:2], 2'b00};
                end else if (!stall) begin
                    pc_d = pc_q + XLEN'(4);
                end
                if_stall = stall;
                if_flush = i_flush_decode;
            end
        endcase
    end

    // Address is the next PC so the word returned next cycle is always mem[pc_q].
    assign o_imem_addr = pc_d;

    assign if_id_d = '{pc: pc_q, instr: i_imem_rdata, valid: 1'b1};

    if_id_reg #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk   (i_clk),
        .rst_n (i_reset),
        .stall (if_stall),
        .flush (if_flush),
        .d     (if_id_d),
        .q     (if_id_q)
    );

    assign o_pc_decode       = if_id_q.pc;
    assign o_instr_decode    = if_id_q.instr;
    assign o_insn_vld_decode = if_id_q.valid;

    // Targets are word aligned; the low bits are intentionally dropped.
    assign unused_alu_lsbs = ^i_alu_data[1:0];

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0): bubble inserted into decode.
REQ-003 i_clk  input  1  single clock; all state updates on rising edge.
REQ-004 i_reset  input  1  asynchronous, active-low reset.
REQ-005 i_stall_fetch  input  1  hold PC (from hazard unit).
REQ-006 i_stall_decode  input  1  hold IF/ID register (from hazard unit).
REQ-007 i_flush_decode  input  1  replace IF/ID contents with a bubble (from hazard unit).
REQ-008 i_pc_sel  input  1  redirect: next PC = i_alu_data.
REQ-009 i_alu_data  input  32  branch/jump target from execute.
REQ-010 o_imem_addr  output  32  instruction memory address, synchronous-read memory.
REQ-011 i_imem_rdata  input  32  word at the address presented on the previous rising edge.
REQ-012 o_pc_decode  output  32  PC of the instruction held in IF/ID.
REQ-013 o_instr_decode  output  32  instruction held in IF/ID.
REQ-014 o_insn_vld_decode  output  1  1 = IF/ID holds a real instruction, 0 = bubble.

Function
REQ-015 The stage SHALL contain a PC register, a two-state FSM (BOOT, RUN) and an IF/ID register (pc, instr, valid).
REQ-016 Next-PC priority SHALL be: i_pc_sel -> {i_alu_data[31:2],2'b00}; else stall -> PC held; else PC+4 (32-bit, wraps 32'hFFFF_FFFC -> 0).
REQ-017 Stall SHALL mean (i_stall_fetch | i_stall_decode); either input alone stalls both PC and IF/ID.
REQ-018 o_imem_addr SHALL equal the combinational next-PC, so i_imem_rdata in the following cycle is always mem[PC].
REQ-019 Redirect SHALL override stall: i_pc_sel=1 with stall=1 loads the target.
REQ-020 In RUN, with no stall and no flush, IF/ID SHALL load {PC, i_imem_rdata, 1} each cycle: one-cycle fetch-to-decode latency.
REQ-021 With stall=1 and i_flush_decode=0, IF/ID SHALL hold all three fields unchanged.
REQ-022 i_flush_decode=1 SHALL load {PC, NOP_INSTR, 0} into IF/ID regardless of stall (flush beats stall).
REQ-023 i_pc_sel=1 without i_flush_decode SHALL still load IF/ID normally; squashing is solely the hazard unit's job.
REQ-024 BOOT SHALL be the reset state; during BOOT, o_imem_addr=RESET_PC, PC is not advanced and IF/ID loads a bubble; BOOT -> RUN unconditionally after one cycle.
REQ-025 In RUN, PC SHALL advance per REQ-016; RUN is left only by reset.
REQ-026 Stall, flush and redirect inputs SHALL be ignored during BOOT.

Reset
REQ-027 While i_reset=0: PC=RESET_PC, state=BOOT, o_pc_decode=RESET_PC, o_instr_decode=NOP_INSTR, o_insn_vld_decode=0; o_imem_addr=RESET_PC.
REQ-028 Reset asserted mid-stall or mid-redirect SHALL take effect immediately (asynchronously) and discard any pending target.
REQ-029 The first real instruction (mem[RESET_PC]) SHALL appear in decode on the second rising edge after reset release.

Structure
REQ-030 The FSM state enum, NOP_INSTR value and the 32-bit XLEN constant SHALL live in the shared pipeline package, together with the IF/ID record typedef (pc, instr, valid).
REQ-031 The IF/ID register SHALL be a sub-module named if_id_reg (inputs: stall, flush, d record; output: q record); PC logic and FSM stay in fetch_stage.

Verification
REQ-032 Reset release, RESET_PC=0, mem[0]=A, mem[4]=B, no hazards -> edge 1: bubble; edge 2: decode {0,A,1}; edge 3: {4,B,1}; o_imem_addr steps 4, 8, 12.
REQ-033 i_stall_fetch=i_stall_decode=1 for 2 cycles while PC=8 -> PC stays 8, o_imem_addr=8, IF/ID frozen; on release decode shows {8,mem[8],1}.
REQ-034 i_pc_sel=1, i_alu_data=32'h0000_0102, i_flush_decode=1 at PC=0x10 -> next PC=0x100, decode {0x10,NOP,0}; one cycle later decode {0x100,mem[0x100],1}.
REQ-035 i_pc_sel=1, stall=1, i_flush_decode=1 simultaneously -> PC loads target (redirect beats stall), IF/ID gets bubble (flush beats stall).
REQ-036 PC=32'hFFFF_FFFC, no hazards -> next PC=0, o_imem_addr=0, no X on any output.
REQ-037 i_reset pulsed low asynchronously between edges during a redirect -> outputs match REQ-027 immediately; the target is never fetched; restart matches REQ-032.
